// File: rtl/cordic_vector_atan2_if.sv
// Handshake bundle for the vectoring CORDIC: operand request side and result side.
// valid/ready: a transfer happens on a rising edge where both are high; valid holds its payload until then.
interface cordic_vector_atan2_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] angle_out;
  logic [31:0] mag_out;
  logic        err_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out, err_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out, err_out
  );
endinterface

// File: rtl/cordic_vector_atan2.sv
// Iterative float32 CORDIC in vectoring mode: one micro-rotation per clock, returns
// atan2(y, x) and the gain-scaled magnitude.
module cordic_vector_atan2 #(
  parameter int ITER = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  cordic_vector_atan2_if.slave        bus,
  output logic [1:0]                  dbg_state_o
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;
  localparam logic [31:0] POS_PI = 32'h40490FDB;
  localparam logic [31:0] NEG_PI = 32'hC0490FDB;
  localparam logic [31:0] SIGN   = 32'h80000000;
  localparam logic [4:0]  LAST   = 5'(ITER - 1);

  // Operands with exponent 0 are zero; results that underflow are flushed to +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [27:0] mb, ms, sum, norm;
    int          pos, e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    d   = big[30:23] - sml[30:23];
    mb  = {2'b01, big[22:0], 3'b000};
    ms  = {2'b01, sml[22:0], 3'b000} >> d;
    sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
    if (sum == 28'd0) return 32'd0;
    pos = 0;
    for (int k = 0; k < 28; k++) if (sum[k]) pos = k;
    norm = (pos == 27) ? (sum >> 1) : (sum << (26 - pos));
    e = int'(big[30:23]) + pos - 26;
    if (e <= 0) return 32'd0;
    if (e >= 255) return {big[31], 8'hFF, 23'd0};
    return {big[31], 8'(e), norm[25:3]};
  endfunction

  function automatic logic [31:0] fshr(input logic [31:0] a, input logic [4:0] i);
    if (a[30:23] <= {3'd0, i}) return 32'd0;
    return {a[31], a[30:23] - {3'd0, i}, a[22:0]};
  endfunction

  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h3F490FDB;
      5'd1:  return 32'h3EED6338;
      5'd2:  return 32'h3E7ADBB0;
      5'd3:  return 32'h3DFEADD5;
      5'd4:  return 32'h3D7FAADE;
      5'd5:  return 32'h3CFFEAAE;
      5'd6:  return 32'h3C7FFAAB;
      5'd7:  return 32'h3BFFFEAB;
      5'd8:  return 32'h3B7FFFAB;
      5'd9:  return 32'h3AFFFFEB;
      5'd10: return 32'h3A7FFFFB;
      5'd11: return 32'h39FFFFFF;
      5'd12: return 32'h39800000;
      5'd13: return 32'h39000000;
      5'd14: return 32'h38800000;
      5'd15: return 32'h38000000;
      default: return 32'd0;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d, zin_q, zin_d;
  logic [31:0] angle_q, angle_d, mag_q, mag_d;
  logic        err_out_q, err_out_d, out_valid_q, out_valid_d;

  logic [31:0] xz, yz, x0, y0, z0;
  logic        in_err, in_zero;
  logic        s;
  logic [31:0] atan_v, x_nx, y_nx, z_nx;

  always_comb begin
    xz      = (bus.x_in[30:23] == 8'd0) ? 32'd0 : bus.x_in;
    yz      = (bus.y_in[30:23] == 8'd0) ? 32'd0 : bus.y_in;
    in_err  = (bus.x_in[30:23] == 8'hFF) || (bus.y_in[30:23] == 8'hFF);
    in_zero = (xz == 32'd0) && (yz == 32'd0);
    x0      = xz[31] ? (xz ^ SIGN) : xz;
    y0      = xz[31] ? (yz ^ SIGN) : yz;
    z0      = xz[31] ? (yz[31] ? NEG_PI : POS_PI) : 32'd0;
  end

  // d = +1 when y is non-negative; the sign of each term is applied by flipping bit 31.
  always_comb begin
    s      = y_q[31];
    atan_v = atan_lut(cnt_q);
    x_nx   = fadd(x_q, fshr(y_q, cnt_q) ^ {s, 31'd0});
    y_nx   = fadd(y_q, fshr(x_q, cnt_q) ^ {~s, 31'd0});
    z_nx   = fadd(z_q, {s, atan_v[30:0]});
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    zin_d       = zin_q;
    angle_d     = angle_q;
    mag_d       = mag_q;
    err_out_d   = err_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_RUN;
          x_d     = x0;
          y_d     = y0;
          z_d     = z0;
          cnt_d   = 5'd0;
          err_d   = in_err;
          zin_d   = in_zero;
        end
      end
      S_RUN: begin
        x_d   = x_nx;
        y_d   = y_nx;
        z_d   = z_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          err_out_d   = err_q;
          // atan2(0,0) is reported as 0 rather than whatever z drifted to.
          angle_d     = (err_q || zin_q) ? 32'd0 : z_nx;
          mag_d       = err_q ? 32'd0 : x_nx;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= 32'd0;
      y_q         <= 32'd0;
      z_q         <= 32'd0;
      cnt_q       <= 5'd0;
      err_q       <= 1'b0;
      zin_q       <= 1'b0;
      angle_q     <= 32'd0;
      mag_q       <= 32'd0;
      err_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      zin_q       <= zin_d;
      angle_q     <= angle_d;
      mag_q       <= mag_d;
      err_out_q   <= err_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.angle_out = angle_q;
  assign bus.mag_out   = mag_q;
  assign bus.err_out   = err_out_q;
  assign dbg_state_o   = state_q;

endmodule
